// File: rtl/clock_pkg.sv
// Shared constants and types for the digital clock display path.
// Segment codes are the active-low {g,f,e,d,c,b,a} patterns; the dp bit is handled separately.
package clock_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   blank;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   blink;
  } snap_t;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD nibble to active-low 7-segment decoder.
// 4'hA shows a dash; 4'hB..4'hF are dark.
module bcd_to_seg
  import clock_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg7
);

  always_comb begin
    seg7 = SEG_BLANK;
    case (bcd)
      4'd0:    seg7 = SEG_0;
      4'd1:    seg7 = SEG_1;
      4'd2:    seg7 = SEG_2;
      4'd3:    seg7 = SEG_3;
      4'd4:    seg7 = SEG_4;
      4'd5:    seg7 = SEG_5;
      4'd6:    seg7 = SEG_6;
      4'd7:    seg7 = SEG_7;
      4'd8:    seg7 = SEG_8;
      4'd9:    seg7 = SEG_9;
      4'hA:    seg7 = SEG_DASH;
      default: seg7 = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed driver for an 8-digit common-anode 7-segment display with
// ghost blanking, frame-coherent input snapshot and a frame-based blink generator.
module seg_scan_driver
  import clock_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYC    = 16,
  parameter int BLINK_FRAMES = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] digits,
  input  logic [7:0]  blank_mask,
  input  logic [7:0]  dp_mask,
  input  logic [7:0]  blink_mask,
  output logic [7:0]  dig,
  output logic [7:0]  seg,
  output logic        frame_start
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_FRAMES + 1);

  logic [SW-1:0] slot_cnt;
  logic [2:0]    idx;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  snap_t         snap;

  logic          frame_tick;
  logic          in_blank;
  logic          dark;
  logic [3:0]    nibble;
  logic [6:0]    seg7;

  assign frame_tick = (slot_cnt == '0) && (idx == 3'd0);
  assign in_blank   = slot_cnt < SW'(BLANK_CYC);
  assign nibble     = snap.digits[{idx, 2'b00} +: 4];
  assign dark       = snap.blank[idx] || (snap.blink[idx] && blink_phase);

  bcd_to_seg u_dec (
    .bcd  (nibble),
    .seg7 (seg7)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt    <= '0;
      idx         <= 3'd0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      snap.digits <= '0;
      snap.blank  <= 8'hFF;
      snap.dp     <= 8'h00;
      snap.blink  <= 8'h00;
      frame_start <= 1'b0;
      dig         <= 8'hFF;
      seg         <= 8'hFF;
    end else begin
      // Counter stage: slot timing and digit index
      if (slot_cnt == SW'(SCAN_DIV - 1)) begin
        slot_cnt <= '0;
        idx      <= idx + 3'd1;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end

      // Snapshot and blink update happen together so a phase change lands on a frame boundary
      frame_start <= frame_tick;
      if (frame_tick) begin
        snap.digits <= digits;
        snap.blank  <= blank_mask;
        snap.dp     <= dp_mask;
        snap.blink  <= blink_mask;
        if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end

      // Output stage: one cycle behind the counter state
      if (in_blank) begin
        dig <= 8'hFF;
        seg <= 8'hFF;
      end else begin
        dig <= ~(8'b1 << idx);
        seg <= dark ? 8'hFF : {~snap.dp[idx], seg7};
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: frame/slot model derived from the cycle count plus
// directed scenarios with literal expectations.
module tb_seg_scan_driver;

  localparam int SD = 4;
  localparam int BC = 1;
  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] digits = 32'h12345678;
  logic [7:0]  blank_mask = 8'h00;
  logic [7:0]  dp_mask = 8'h00;
  logic [7:0]  blink_mask = 8'h00;
  logic [7:0]  dig;
  logic [7:0]  seg;
  logic        frame_start;

  int tests = 0;
  int fails = 0;
  bit started = 1'b0;

  // Model state: k counts clock edges since reset release
  int          k = 0;
  int          m_pos, m_slot, m_frame, m_phase;
  logic        m_dark;
  logic [7:0]  m_code;
  logic [31:0] m_digits = 32'h0;
  logic [7:0]  m_blank = 8'hFF;
  logic [7:0]  m_dp = 8'h00;
  logic [7:0]  m_blink = 8'h00;
  logic [7:0]  e_dig = 8'hFF;
  logic [7:0]  e_seg = 8'hFF;
  logic        e_fs = 1'b0;

  seg_scan_driver #(
    .SCAN_DIV     (SD),
    .BLANK_CYC    (BC),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .digits      (digits),
    .blank_mask  (blank_mask),
    .dp_mask     (dp_mask),
    .blink_mask  (blink_mask),
    .dig         (dig),
    .seg         (seg),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] code(input logic [3:0] n);
    case (n)
      4'd0: return 8'hC0;
      4'd1: return 8'hF9;
      4'd2: return 8'hA4;
      4'd3: return 8'hB0;
      4'd4: return 8'h99;
      4'd5: return 8'h92;
      4'd6: return 8'h82;
      4'd7: return 8'hF8;
      4'd8: return 8'h80;
      4'd9: return 8'h90;
      4'hA: return 8'hBF;
      default: return 8'hFF;
    endcase
  endfunction

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at k=%0d: got %02h expected %02h", name, k, act, exp);
    end
  endtask

  task automatic wait_k(input int target);
    while (k < target) @(negedge clk);
  endtask

  // Behavioural model: position in slot/frame follows directly from the edge count
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      k = 0;
      e_dig = 8'hFF;
      e_seg = 8'hFF;
      e_fs = 1'b0;
    end else begin
      k++;
      m_pos   = (k - 1) % SD;
      m_slot  = ((k - 1) / SD) % 8;
      m_frame = (k - 1) / (SD * 8);
      e_fs    = (m_pos == 0) && (m_slot == 0);
      if (e_fs) begin
        m_digits = digits;
        m_blank  = blank_mask;
        m_dp     = dp_mask;
        m_blink  = blink_mask;
      end
      m_phase = ((m_frame + 1) / BF) % 2;
      if (m_pos < BC) begin
        e_dig = 8'hFF;
        e_seg = 8'hFF;
      end else begin
        e_dig  = ~(8'd1 << m_slot);
        m_dark = m_blank[m_slot] || (m_blink[m_slot] && (m_phase == 1));
        m_code = code(m_digits[m_slot*4 +: 4]);
        if (m_dark) e_seg = 8'hFF;
        else if (m_dp[m_slot]) e_seg = m_code & 8'h7F;
        else e_seg = m_code | 8'h80;
      end
    end
  end

  // Every-cycle comparison against the model plus the one-hot-low invariant
  initial forever begin
    @(negedge clk);
    if (started) begin
      check8("model_dig", dig, e_dig);
      check8("model_seg", seg, e_seg);
      check8("model_fs", {7'd0, frame_start}, {7'd0, e_fs});
      tests++;
      if ($countones(~dig) > 1) begin
        fails++;
        $display("FAIL onehot at k=%0d: dig=%02h has more than one low bit", k, dig);
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check8("reset_dig", dig, 8'hFF);
    check8("reset_seg", seg, 8'hFF);
    check8("reset_fs", {7'd0, frame_start}, 8'h00);
    started = 1'b1;
    rst = 1'b0;

    // Scenario 1: first frame of 12345678
    wait_k(1);
    check8("s1_fs", {7'd0, frame_start}, 8'h01);
    check8("s1_gap_dig", dig, 8'hFF);
    wait_k(2);
    check8("s1_d0_dig", dig, 8'hFE);
    check8("s1_d0_seg", seg, 8'h80);
    wait_k(5);
    check8("s1_gap1_dig", dig, 8'hFF);
    wait_k(6);
    check8("s1_d1_dig", dig, 8'hFD);
    check8("s1_d1_seg", seg, 8'hF8);

    // Scenario 2: mid-frame change must not tear
    wait_k(10);
    digits = 32'h99999999;
    wait_k(30);
    check8("s2_old_dig", dig, 8'h7F);
    check8("s2_old_seg", seg, 8'hF9);
    wait_k(33);
    check8("s2_fs", {7'd0, frame_start}, 8'h01);
    wait_k(34);
    check8("s2_new_seg", seg, 8'h90);

    // Scenario 3: blank and decimal point
    wait_k(40);
    digits = 32'h99999909;
    blank_mask = 8'h01;
    dp_mask = 8'h02;
    wait_k(66);
    check8("s3_blank_dig", dig, 8'hFE);
    check8("s3_blank_seg", seg, 8'hFF);
    wait_k(70);
    check8("s3_dp_dig", dig, 8'hFD);
    check8("s3_dp_seg", seg, 8'h40);

    // Scenario 4: blink on digit 7, captured from frame 3
    blink_mask = 8'h80;
    wait_k(126);
    check8("s4_f3_seg", seg, 8'h90);
    wait_k(158);
    check8("s4_f4_seg", seg, 8'h90);
    wait_k(186);
    check8("s4_f5_d6_seg", seg, 8'h90);
    wait_k(190);
    check8("s4_f5_dig", dig, 8'h7F);
    check8("s4_f5_seg", seg, 8'hFF);
    wait_k(222);
    check8("s4_f6_seg", seg, 8'hFF);
    wait_k(254);
    check8("s4_f7_seg", seg, 8'h90);

    // Scenario 5: non-decimal nibbles
    digits = 32'h999FBA99;
    blank_mask = 8'h00;
    dp_mask = 8'h00;
    blink_mask = 8'h00;
    wait_k(262);
    check8("s5_d1_seg", seg, 8'h90);
    wait_k(266);
    check8("s5_a_dig", dig, 8'hFB);
    check8("s5_a_seg", seg, 8'hBF);
    wait_k(270);
    check8("s5_b_seg", seg, 8'hFF);
    wait_k(274);
    check8("s5_f_dig", dig, 8'hEF);
    check8("s5_f_seg", seg, 8'hFF);

    // Scenario 6: asynchronous reset mid-slot
    wait_k(291);
    #2;
    rst = 1'b1;
    #1;
    check8("s6_async_dig", dig, 8'hFF);
    check8("s6_async_seg", seg, 8'hFF);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_k(1);
    check8("s6_fs", {7'd0, frame_start}, 8'h01);
    wait_k(2);
    check8("s6_d0_dig", dig, 8'hFE);
    check8("s6_d0_seg", seg, 8'h90);
    wait_k(80);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
